uart_tx: RTL
============

Name: uart_tx

Overview:
- UART serial transmitter; transmit-side counterpart of the team's uart_rx in the 27 MHz serial I/O path.
- Accepts one byte per valid/ready handshake and serialises it LSB-first on `tx`.
- Frame format: start bit, 8 data bits, optional parity bit, 1 or 2 stop bits.
- Default baud rate is 9600, matching the receiver, so uart_tx to uart_rx loopback works without configuration changes.

Parameters:
- CLK_FREQ, 27000000: clock frequency in Hz.
- BAUD_RATE, 9600: bit rate in bits/s.
- PARITY_EN, 0: 1 inserts a parity bit after data bit 7.
- PARITY_ODD, 0: parity sense when PARITY_EN=1. 0 = even, 1 = odd.
- STOP_BITS, 1: number of stop bits. Legal values are 1 and 2.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- tx_data  input  8  byte to transmit. Sampled only at handshake.
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  transmitter can accept a byte this cycle.
- tx  output  1  serial line. Idles high.
- tx_busy  output  1  a frame is in progress (state != IDLE).

Behaviour:
- Derived constant CLKS_PER_BIT = CLK_FREQ/BAUD_RATE, integer division.
  - Defaults give 2812.
  - Elaboration error if CLKS_PER_BIT < 2, or if STOP_BITS is not 1 or 2.
- Baud counter width is $clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1, then wraps to 0.
- Reset (asynchronous, takes effect immediately while asserted):
  - state=IDLE, tx=1, tx_busy=0, tx_ready=1.
  - Baud counter, bit index and shift register are cleared.
- Output registration:
  - tx is registered; no combinational path from inputs to tx.
  - tx_ready is a decode of state==IDLE.
  - tx_busy = !tx_ready.
- State machine: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - IDLE: tx=1.
    - Handshake occurs when tx_valid && tx_ready at a rising edge.
    - On handshake: latch tx_data into the shift register, compute the parity bit (XOR of the byte, inverted if PARITY_ODD), clear the baud counter, and go to START.
    - tx goes 0 on that same edge, i.e. the first cycle after acceptance.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles, then shift right and increment the bit index.
    - After bit 7 completes, go to PARITY if PARITY_EN, else to STOP.
  - PARITY: tx=parity bit for CLKS_PER_BIT cycles, then go to STOP.
  - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles, then go to IDLE.
- Frame length: exactly (10 + PARITY_EN + STOP_BITS - 1)*CLKS_PER_BIT cycles from the first start-bit cycle to the end of the last stop bit.
  - Defaults: 28120 cycles.
- Back-to-back transfers:
  - tx_ready rises in the cycle after the last stop-bit cycle.
  - If tx_valid is held high, the next byte is accepted in that cycle. The next start bit follows one clk later.
  - Inter-frame gap is therefore exactly 1 clk of idle-high.
- Data stability: tx_data and tx_valid changes during a frame are ignored. The latched byte is transmitted unaltered.
- tx_valid with tx_ready=0: no effect. A source must hold tx_valid until it sees the handshake.
- Reset mid-frame:
  - Frame is aborted and tx returns to 1 immediately.
  - No partial frame resumes after release.
  - First acceptance is possible on the first rising edge after reset deasserts.

Test Plan:
1. Default 8N1: send 0xAA with a single-cycle valid.
   - Sample tx at mid-bit (cycle offset 1406 + k*2812): sequence 0,0,1,0,1,0,1,0,1,1.
   - tx_busy high for 28120 cycles.
   - tx_ready low from the cycle after acceptance until the frame ends.
2. Back-to-back: hold tx_valid with 0x55 then 0x0F.
   - Second start-bit falling edge occurs exactly 28121 cycles after the first.
   - Decoded bytes are 0x55, 0x0F.
   - tx_data changed mid-frame (to 0xFF) does not corrupt the bytes.
3. Parity and stop bits: PARITY_EN=1.
   - PARITY_ODD=0 with 0x07: parity bit=1.
   - PARITY_ODD=1 with 0x07: parity bit=0.
   - With STOP_BITS=2 added: frame = 12*2812 = 33744 cycles, stop level high for 5624 cycles.
4. Reset mid-frame: assert reset during data bit 3 of 0xA5.
   - tx=1 and tx_ready=1 without waiting for a clock edge.
   - After release, 0x3C transmits a clean full frame.
5. Loopback: connect tx to uart_rx (27 MHz, 9600 baud) and send 0xAA, 0x00, 0xFF.
   - uart_rx data_out matches each byte within 1.5 bit times after the stop bit.
6. Idle and no-handshake: with tx_valid=0 for 100000 cycles after reset.
   - tx stays 1, tx_busy stays 0, tx_ready stays 1.

Source files
------------

// File: rtl/uart_tx.sv
// uart_tx: 8-bit UART transmitter, LSB first, optional parity, 1 or 2 stop bits
module uart_tx #(
    parameter int CLK_FREQ   = 27000000,
    parameter int BAUD_RATE  = 9600,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       tx_busy
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int CW = $clog2(CLKS_PER_BIT);

    if (CLKS_PER_BIT < 2 || (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_cfg
        $error("uart_tx: CLKS_PER_BIT must be >= 2 and STOP_BITS must be 1 or 2");
    end

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic          stop2_q, stop2_d;
    logic          tx_q, tx_d;
    logic          cnt_last;

    assign cnt_last = cnt_q == CW'(CLKS_PER_BIT - 1);
    assign tx_ready = state_q == IDLE;
    assign tx_busy  = !tx_ready;
    assign tx       = tx_q;

    // Next state; tx_d is decoded from the next state so tx changes on the same edge as the state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_last ? '0 : cnt_q + 1'b1;
        idx_d   = idx_q;
        shift_d = shift_q;
        par_d   = par_q;
        stop2_d = stop2_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (tx_valid) begin
                    shift_d = tx_data;
                    par_d   = ^tx_data ^ (PARITY_ODD != 0);
                    state_d = START;
                end
            end
            START: begin
                stop2_d = 1'b0;
                if (cnt_last) begin
                    idx_d   = 3'd0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (cnt_last) begin
                    shift_d = shift_q >> 1;
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == 3'd7) state_d = (PARITY_EN != 0) ? PARITY : STOP;
                end
            end
            PARITY: state_d = cnt_last ? STOP : PARITY;
            STOP: begin
                if (cnt_last) begin
                    if (STOP_BITS == 2 && !stop2_q) stop2_d = 1'b1;
                    else state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        tx_d = state_d == START  ? 1'b0 :
               state_d == DATA   ? shift_d[0] :
               state_d == PARITY ? par_d : 1'b1;
    end

    // State registers; reset aborts any frame and forces the line idle immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            stop2_q <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            stop2_q <= stop2_d;
            tx_q    <= tx_d;
        end
    end
endmodule
